// File: rtl/fifo_pair_adder_pkg.sv
// Shared FSM state type and default widths for the FIFO pair adder.
package fifo_pair_adder_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefPairs = 4;
  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefCntW  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPopA,
    StLatA,
    StPopB,
    StLatB,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/fifo_pair_adder_pair_addsub.sv
// Combinational adder/subtractor producing A+B or A-B with a signed-overflow flag.
module pair_addsub
  import fifo_pair_adder_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_sub,
  output logic [DATA_W-1:0] o_sum,
  output logic              o_ovf
);

  logic [DATA_W-1:0] w_b_op;

  always_comb begin
    // Subtraction as A + ~B + 1 so one adder serves both operations.
    w_b_op = i_sub ? ~i_b : i_b;
    o_sum  = i_a + w_b_op + {{(DATA_W-1){1'b0}}, i_sub};
    o_ovf  = (i_a[DATA_W-1] == w_b_op[DATA_W-1]) && (o_sum[DATA_W-1] != i_a[DATA_W-1]);
  end

endmodule

// File: rtl/fifo_pair_adder.sv
// Pops operand pairs from a FIFO, adds/subtracts them and writes results to a register file.
// Optional sticky signed-overflow output enabled by defining FIFO_PAIR_ADDER_OVF_EN.
module fifo_pair_adder
  import fifo_pair_adder_pkg::*;
#(
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned PAIRS     = DefPairs,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned CNT_W     = DefCntW,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic              op_sub,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_re,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              op_done
`ifdef FIFO_PAIR_ADDER_OVF_EN
  ,
  output logic              ovf
`endif
);

  state_e            r_state;
  state_e            w_state_d;
  logic [ADDR_W-1:0] r_idx;
  logic              r_sub;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_pop;
  logic              w_write;
  logic              w_last;
  logic              w_has_data;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_sum;
  logic              w_ovf;

  assign w_has_data = (fifo_count != '0);
  assign w_last     = (r_idx == ADDR_W'(PAIRS - 1));
  assign w_addr     = ADDR_W'(BASE_ADDR) + r_idx;

  pair_addsub #(
    .DATA_W (DATA_W)
  ) u_addsub (
    .i_a   (r_a),
    .i_b   (r_b),
    .i_sub (r_sub),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    if (op_clear) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (op_start) w_state_d = StPopA;
        StPopA:  w_state_d = !op_start ? StIdle : (w_has_data ? StLatA : StPopA);
        StLatA:  w_state_d = !op_start ? StIdle : StPopB;
        StPopB:  w_state_d = !op_start ? StIdle : (w_has_data ? StLatB : StPopB);
        StLatB:  w_state_d = !op_start ? StIdle : StWrite;
        StWrite: w_state_d = !op_start ? StIdle : (w_last ? StDone : StPopA);
        StDone:  if (!op_start) w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Strobes are qualified by op_start/op_clear so an abort or clear never pops or writes.
  always_comb begin
    w_pop   = 1'b0;
    w_write = 1'b0;
    if (op_start && !op_clear) begin
      w_pop   = ((r_state == StPopA) || (r_state == StPopB)) && w_has_data;
      w_write = (r_state == StWrite);
    end
    fifo_re  = w_pop;
    rf_we    = w_write;
    rf_waddr = w_write ? w_addr : r_waddr;
    rf_wdata = w_write ? w_sum : r_wdata;
    busy     = (r_state != StIdle) && (r_state != StDone);
    op_done  = (r_state == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= '0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (op_clear) begin
      r_idx   <= '0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if ((r_state == StIdle) && op_start) begin
        r_idx <= '0;
        r_sub <= op_sub;
      end
      if ((r_state == StLatA) && op_start) r_a <= fifo_dout;
      if ((r_state == StLatB) && op_start) r_b <= fifo_dout;
      if (w_write) begin
        r_waddr <= w_addr;
        r_wdata <= w_sum;
        if (!w_last) r_idx <= r_idx + ADDR_W'(1);
      end
    end
  end

`ifdef FIFO_PAIR_ADDER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (op_clear || ((r_state == StIdle) && op_start)) begin
      r_ovf <= 1'b0;
    end else if (w_write && w_ovf) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
`endif

endmodule

// File: tb/tb_fifo_pair_adder.sv
// Self-checking bench for fifo_pair_adder: FIFO model, write scoreboard and vector table.
`timescale 1ns/1ps
module tb_fifo_pair_adder;

  localparam int DW    = 32;
  localparam int NP    = 4;
  localparam int AW    = 4;
  localparam int CW    = 4;
  localparam int BASE  = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic          op_start;
  logic          op_clear;
  logic          op_sub;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_dout;
  logic          fifo_re;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          busy;
  logic          op_done;
`ifdef FIFO_PAIR_ADDER_OVF_EN
  logic          ovf;
`endif

  fifo_pair_adder #(
    .DATA_W    (DW),
    .PAIRS     (NP),
    .ADDR_W    (AW),
    .CNT_W     (CW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op_start   (op_start),
    .op_clear   (op_clear),
    .op_sub     (op_sub),
    .fifo_count (fifo_count),
    .fifo_dout  (fifo_dout),
    .fifo_re    (fifo_re),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .op_done    (op_done)
`ifdef FIFO_PAIR_ADDER_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  vec_t        tv[8];
  wr_t         sb[$];
  logic [31:0] fq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // FIFO model: fifo_re seen in a cycle pops at the next edge; dout valid the cycle after.
  initial begin
    bit pop_pend;
    fifo_count = '0;
    fifo_dout  = '0;
    forever begin
      @(negedge clk);
      #3;
      pop_pend = fifo_re;
      if (fifo_re) check("re_with_data", 32'(fifo_count != '0), 32'd1);
      @(posedge clk);
      #1;
      if (pop_pend && fq.size() != 0) fifo_dout = fq.pop_front();
      fifo_count = CW'(fq.size());
    end
  end

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(rf_waddr), 32'(e.addr));
        check("wr_data", rf_wdata, e.data);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "timeout");
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit exp_wr,
                           input int idx, input logic [31:0] exp);
    wr_t w;
    fq.push_back(a);
    fq.push_back(b);
    if (exp_wr) begin
      w.addr = AW'((BASE + idx) % 16);
      w.data = exp;
      sb.push_back(w);
    end
  endtask

  // Leaves the bench just after the edge-1 input drive; next negedge follows edge 1.
  task automatic start_op(input logic sub);
    @(negedge clk);
    @(negedge clk);
    #1;
    op_sub   = sub;
    op_start = 1'b1;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!op_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", 32'(op_done), 32'd1);
    #1;
    op_start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input int first);
    int first_we;
    int done_k;
    first_we = -1;
    done_k   = -1;
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      push_pair(tv[first+i].a, tv[first+i].b, 1'b1, i, tv[first+i].exp);
    end
    start_op(tv[first].sub);
    for (int k = 1; k <= 200 && done_k < 0; k++) begin
      @(negedge clk);
      if (rf_we && first_we < 0) first_we = k;
      if (op_done) done_k = k;
    end
    check("first_we_cycle", first_we, 32'd5);
    check("done_cycle", done_k, 32'd21);
    check("busy_in_done", 32'(busy), 32'd0);
    #1;
    op_start = 1'b0;
    @(negedge clk);
    check("idle_done_low", 32'(op_done), 32'd0);
    check("idle_busy_low", 32'(busy), 32'd0);
    check("hold_waddr", 32'(rf_waddr), 32'((BASE + 3) % 16));
    check("hold_wdata", rf_wdata, tv[first+3].exp);
  endtask

  initial begin
    int n_re;
    tv[0] = '{sub: 1'b0, a: 32'd1,          b: 32'd2,  exp: 32'd3};
    tv[1] = '{sub: 1'b0, a: 32'd3,          b: 32'd4,  exp: 32'd7};
    tv[2] = '{sub: 1'b0, a: 32'd5,          b: 32'd6,  exp: 32'd11};
    tv[3] = '{sub: 1'b0, a: 32'd7,          b: 32'd8,  exp: 32'd15};
    tv[4] = '{sub: 1'b1, a: 32'd10,         b: 32'd3,  exp: 32'd7};
    tv[5] = '{sub: 1'b1, a: 32'd3,          b: 32'd10, exp: 32'hFFFF_FFF9};
    tv[6] = '{sub: 1'b1, a: 32'd0,          b: 32'd1,  exp: 32'hFFFF_FFFF};
    tv[7] = '{sub: 1'b1, a: 32'h8000_0000,  b: 32'd1,  exp: 32'h7FFF_FFFF};

    reset    = 1'b1;
    op_start = 1'b0;
    op_clear = 1'b0;
    op_sub   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fifo_re", 32'(fifo_re), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_waddr", 32'(rf_waddr), 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(op_done), 32'd0);
`ifdef FIFO_PAIR_ADDER_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    #1;
    reset = 1'b0;

    // Table-driven operations: additions then subtractions.
    for (int g = 0; g < 8; g += NP) run_op(g);

    // Stall at POP_B with an empty FIFO, then resume.
    @(negedge clk);
    #1;
    fq.push_back(32'd100);
    sb.push_back('{addr: AW'(BASE % 16), data: 32'd300});
    start_op(1'b0);
    @(negedge clk);
    n_re = 0;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      if (fifo_re) n_re++;
    end
    check("stall_no_re", n_re, 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    #1;
    fq.push_back(32'd200);
    for (int i = 1; i < NP; i++) push_pair(i, i, 1'b1, i, 2 * i);
    wait_done();

    // op_clear during LAT_B of pair 2.
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) push_pair(32'd5 + i, 32'd5, i < 2, i, 32'd10 + i);
    start_op(1'b0);
    repeat (14) @(negedge clk);
    check("clr_pre_busy", 32'(busy), 32'd1);
    #1;
    op_clear = 1'b1;
    @(negedge clk);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_rf_we", 32'(rf_we), 32'd0);
    check("clr_fifo_re", 32'(fifo_re), 32'd0);
    check("clr_waddr", 32'(rf_waddr), 32'd0);
    check("clr_wdata", rf_wdata, 32'd0);
    check("clr_done", 32'(op_done), 32'd0);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    fq.delete();
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of the first WRITE.
    #1;
    for (int i = 0; i < NP; i++) push_pair(32'd40, 32'd2, 1'b0, i, 32'd0);
    start_op(1'b0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2;
    check("wr_visible", 32'(rf_we), 32'd1);
    check("wr_visible_data", rf_wdata, 32'd42);
    reset    = 1'b1;
    op_start = 1'b0;
    #1;
    check("arst_rf_we", 32'(rf_we), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wdata", rf_wdata, 32'd0);
    check("arst_waddr", 32'(rf_waddr), 32'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    fq.delete();
    repeat (2) @(negedge clk);
    check("arst_no_commit", rf_wdata, 32'd0);
    #1;
    push_pair(32'd9, 32'd9, 1'b1, 0, 32'd18);
    for (int i = 1; i < NP; i++) push_pair(32'd1, i, 1'b1, i, 32'd1 + i);
    start_op(1'b0);
    wait_done();

    // Abort by dropping op_start during pair 1.
    @(negedge clk);
    #1;
    for (int i = 0; i < NP; i++) push_pair(32'd20, 32'd1, i == 0, i, 32'd21);
    start_op(1'b0);
    repeat (7) @(negedge clk);
    #1;
    op_start = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    n_re = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (fifo_re || rf_we) n_re++;
    end
    check("abort_quiet", n_re, 32'd0);
    #1;
    fq.delete();
    repeat (2) @(negedge clk);

`ifdef FIFO_PAIR_ADDER_OVF_EN
    #1;
    push_pair(32'h7FFF_FFFF, 32'd1, 1'b1, 0, 32'h8000_0000);
    for (int i = 1; i < NP; i++) push_pair(32'd0, 32'd0, 1'b1, i, 32'd0);
    start_op(1'b0);
    wait_done();
    check("ovf_sticky", 32'(ovf), 32'd1);
    #1;
    op_clear = 1'b1;
    @(negedge clk);
    check("ovf_cleared", 32'(ovf), 32'd0);
    #1;
    op_clear = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
